// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback unit.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    // One buffered register write: destination and value.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // One-hot encoding of a register index, used to build the pending mask.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] idx);
        return NREGS'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for load results. Every slot is visible at once, with a
// valid bit, so the top level can build the pending mask and the bypass.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output wb_entry_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]        valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    wb_entry_t     mem_reg [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; reset discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    // Storage needs no reset: slot contents only matter while their valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - rd_ptr_reg;
            assign valid[gi]   = ({1'b0, offset} < count_reg);
            assign entries[gi] = mem_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/reg_writeback.sv
// Writeback unit: merges ALU and load results into the single registered
// register-file write port, and exposes pending writes for stall and bypass.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        wEn,
    output logic [4:0]  addrD,
    output logic [31:0] dataD,
    output logic [31:0] pend_mask,
    input  logic [4:0]  fwd_addrA,
    input  logic [4:0]  fwd_addrB,
    output logic        fwd_hitA,
    output logic        fwd_hitB,
    output logic [31:0] fwd_dataA,
    output logic [31:0] fwd_dataB
);

    wb_entry_t              fifo_head;
    wb_entry_t [DEPTH-1:0]  fifo_ent;
    logic [DEPTH-1:0]       fifo_vld;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   alu_take;
    logic                   fifo_pop;
    logic                   lsu_push;

    // ALU wins the port; writes to x0 are dropped so they never block a pop.
    assign alu_take  = alu_valid && (alu_rd != '0);
    assign fifo_pop  = !alu_take && !fifo_empty;
    assign lsu_ready = !fifo_full;
    // Loads to x0 complete the handshake but are not stored.
    assign lsu_push  = lsu_valid && lsu_ready && (lsu_rd != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (lsu_push),
        .push_entry ('{rd: lsu_rd, data: lsu_data}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .entries    (fifo_ent),
        .valid      (fifo_vld)
    );

    // Output stage: address/data hold their last value when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wEn   <= 1'b0;
            addrD <= '0;
            dataD <= '0;
        end else if (alu_take) begin
            wEn   <= 1'b1;
            addrD <= alu_rd;
            dataD <= alu_data;
        end else if (fifo_pop) begin
            wEn   <= 1'b1;
            addrD <= fifo_head.rd;
            dataD <= fifo_head.data;
        end else begin
            wEn   <= 1'b0;
        end
    end

    // Per-slot mask contribution and bypass matches.
    logic [31:0]      slot_mask [DEPTH];
    logic [DEPTH-1:0] slot_hit_a;
    logic [DEPTH-1:0] slot_hit_b;
    logic             out_hit_a;
    logic             out_hit_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign slot_mask[gi]  = fifo_vld[gi] ? reg_onehot(fifo_ent[gi].rd) : '0;
            assign slot_hit_a[gi] = fifo_vld[gi] && (fwd_addrA != '0) && (fifo_ent[gi].rd == fwd_addrA);
            assign slot_hit_b[gi] = fifo_vld[gi] && (fwd_addrB != '0) && (fifo_ent[gi].rd == fwd_addrB);
        end
    endgenerate

    assign out_hit_a = wEn && (fwd_addrA != '0) && (addrD == fwd_addrA);
    assign out_hit_b = wEn && (fwd_addrB != '0) && (addrD == fwd_addrB);
    assign fwd_hitA  = out_hit_a || (|slot_hit_a);
    assign fwd_hitB  = out_hit_b || (|slot_hit_b);

    // OR-trees: at most one pending write per register, so OR-ing masked data selects it.
    always_comb begin
        pend_mask = wEn ? reg_onehot(addrD) : '0;
        fwd_dataA = out_hit_a ? dataD : '0;
        fwd_dataB = out_hit_b ? dataD : '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask = pend_mask | slot_mask[i];
            fwd_dataA = fwd_dataA | (slot_hit_a[i] ? fifo_ent[i].data : '0);
            fwd_dataB = fwd_dataB | (slot_hit_b[i] ? fifo_ent[i].data : '0);
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes go into a scoreboard
// queue, a negedge monitor pops and compares every write the DUT presents.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        wEn;
    logic [4:0]  addrD;
    logic [31:0] dataD;
    logic [31:0] pend_mask;
    logic [4:0]  fwd_addrA = '0;
    logic [4:0]  fwd_addrB = '0;
    logic        fwd_hitA, fwd_hitB;
    logic [31:0] fwd_dataA, fwd_dataB;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q [$];
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wEn(wEn), .addrD(addrD), .dataD(dataD), .pend_mask(pend_mask),
        .fwd_addrA(fwd_addrA), .fwd_addrB(fwd_addrB),
        .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB),
        .fwd_dataA(fwd_dataA), .fwd_dataB(fwd_dataB)
    );

    // Register file model fed by the write port, used for readback.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (!rst && wEn) rf[addrD] <= dataD;

    // Ordering contract: never accept a result whose rd is already pending.
    always @(posedge clk) begin
        if (!rst && alu_valid && alu_rd != 0)
            assert (!pend_mask[alu_rd]) else $error("ALU rd %0d already pending", alu_rd);
        if (!rst && lsu_valid && lsu_ready && lsu_rd != 0)
            assert (!pend_mask[lsu_rd]) else $error("LSU rd %0d already pending", lsu_rd);
    end

    // Monitor: every presented write must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && wEn) begin
            logic [36:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got x%0d=%h required none", addrD, dataD);
            end else begin
                e = exp_q.pop_front();
                if ({addrD, dataD} !== e) begin
                    fails++;
                    $display("FAIL write_order: got x%0d=%h required x%0d=%h",
                             addrD, dataD, e[36:32], e[31:0]);
                end else begin
                    $display("[TB] write x%0d = %h", addrD, dataD);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("[TB] check %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    initial begin
        int budget;
        #1 rst = 1'b1;
        fwd_addrA = 5'd5;
        tick(); tick();
        check("reset_wEn", {31'd0, wEn}, 32'd0);
        check("reset_addrD", {27'd0, addrD}, 32'd0);
        check("reset_dataD", dataD, 32'd0);
        check("reset_pend", pend_mask, 32'd0);
        check("reset_ready", {31'd0, lsu_ready}, 32'd1);
        check("reset_hitA", {31'd0, fwd_hitA}, 32'd0);
        #2 rst = 1'b0;
        tick();

        // ALU path
        drive_alu(1, 5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        drive_alu(0, 0, 0);
        check("alu_wEn", {31'd0, wEn}, 32'd1);
        check("alu_pend", pend_mask, 32'h0000_0020);
        tick();
        check("alu_pend_clear", pend_mask, 32'd0);
        check("alu_readback_x5", rf[5], 32'hDEADBEEF);

        // Fill while ALU starves the FIFO, then drain in order
        for (int k = 1; k <= 4; k++) begin
            check("fill_ready_before", {31'd0, lsu_ready}, 32'd1);
            drive_alu(1, 5'(19 + k), 32'h100 + k); expect_wr(5'(19 + k), 32'h100 + k);
            drive_lsu(1, 5'(k), 32'h11 * k);
            tick();
        end
        check("full_ready", {31'd0, lsu_ready}, 32'd0);
        check("full_pend", pend_mask, 32'h0080_001E);
        drive_alu(1, 5'd24, 32'h124); expect_wr(5'd24, 32'h124);
        drive_lsu(1, 5'd5, 32'h55);   // offered while full: must not be taken
        tick();
        drive_alu(0, 0, 0); drive_lsu(0, 0, 0);
        check("full_hold_ready", {31'd0, lsu_ready}, 32'd0);
        check("full_hold_pend", pend_mask, 32'h0100_001E);
        for (int k = 1; k <= 4; k++) expect_wr(5'(k), 32'h11 * k);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("drain_wEn", {27'd0, addrD}, 32'(k));
        end
        tick();
        check("drain_ready", {31'd0, lsu_ready}, 32'd1);
        check("drain_pend", pend_mask, 32'd0);

        // Priority: ALU writes go ahead of the queued load
        drive_lsu(1, 5'd7, 32'h77);
        tick();
        drive_lsu(0, 0, 0);
        expect_wr(5'd9, 32'h99); expect_wr(5'd10, 32'hAA); expect_wr(5'd7, 32'h77);
        check("prio_pend7_a", {31'd0, pend_mask[7]}, 32'd1);
        drive_alu(1, 5'd9, 32'h99);
        tick();
        check("prio_pend7_b", {31'd0, pend_mask[7]}, 32'd1);
        drive_alu(1, 5'd10, 32'hAA);
        tick();
        check("prio_pend7_c", {31'd0, pend_mask[7]}, 32'd1);
        drive_alu(0, 0, 0);
        tick();
        check("prio_pop7", {27'd0, addrD}, 32'd7);
        tick();
        check("prio_pend_clear", pend_mask, 32'd0);

        // Zero register: ALU x0 does not block a pop; LSU x0 accepted, not stored
        drive_lsu(1, 5'd3, 32'h33); expect_wr(5'd3, 32'h33);
        tick();
        drive_lsu(0, 0, 0);
        drive_alu(1, 5'd0, 32'hBAD);
        tick();
        drive_alu(0, 0, 0);
        check("zero_pop_same_cycle", {26'd0, wEn, addrD}, {26'd0, 1'b1, 5'd3});
        drive_lsu(1, 5'd0, 32'hBAD);
        check("zero_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        drive_lsu(0, 0, 0);
        tick();
        check("zero_lsu_nowrite", {31'd0, wEn}, 32'd0);
        check("zero_lsu_pend", pend_mask, 32'd0);

        // Bypass from FIFO, then from output stage
        fwd_addrA = 5'd12; fwd_addrB = 5'd0;
        drive_lsu(1, 5'd12, 32'hCAFE); expect_wr(5'd12, 32'hCAFE);
        tick();
        drive_lsu(0, 0, 0);
        check("byp_hitA", {31'd0, fwd_hitA}, 32'd1);
        check("byp_dataA", fwd_dataA, 32'h0000CAFE);
        check("byp_hitB", {31'd0, fwd_hitB}, 32'd0);
        check("byp_dataB", fwd_dataB, 32'd0);
        tick();
        check("byp_stage_dataA", fwd_dataA, 32'h0000CAFE);
        tick();
        check("byp_gone_hitA", {31'd0, fwd_hitA}, 32'd0);
        check("byp_gone_dataA", fwd_dataA, 32'd0);

        // Reset mid-stream with three loads queued behind ALU traffic
        for (int k = 0; k < 3; k++) begin
            drive_alu(1, 5'(25 + k), 32'h200 + k); expect_wr(5'(25 + k), 32'h200 + k);
            drive_lsu(1, 5'(13 + k), 32'h300 + k);
            tick();
        end
        drive_alu(0, 0, 0); drive_lsu(0, 0, 0);
        check("rst_pre_pend", pend_mask, 32'h0800_E000);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_wEn", {31'd0, wEn}, 32'd0);
        check("rst_async_pend", pend_mask, 32'd0);
        check("rst_async_ready", {31'd0, lsu_ready}, 32'd1);
        tick(); tick();
        #2 rst = 1'b0;
        tick();
        check("rst_after_ready", {31'd0, lsu_ready}, 32'd1);
        check("rst_after_wEn", {31'd0, wEn}, 32'd0);

        // Let the scoreboard empty, bounded
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("x0_never_written", rf[0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
